// File: rtl/membrane_ctrl.sv
// Player control block: debounces the three board buttons, then on each frame strobe
// updates the shared membrane type, membrane_on and the freeze countdown for every molecule.
module membrane_ctrl #(
  parameter int DB_CYCLES     = 500000,
  parameter int DB_W          = 20,
  parameter int FREEZE_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame,
  input  logic       btnU,
  input  logic       btnC,
  input  logic       btnD,
  output logic       no_membrane,
  output logic       magenta_membrane,
  output logic       red_membrane,
  output logic       blue_membrane,
  output logic       membrane_on,
  output logic       freeze,
  output logic [7:0] freeze_left
);

  typedef enum logic [1:0] {T_NONE, T_MAGENTA, T_RED, T_BLUE} mtype_t;
  typedef enum logic {RUN, FROZEN} frz_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam int BU = 0;
  localparam int BC = 1;
  localparam int BD = 2;

  logic [2:0]      raw;
  logic [2:0]      sync1_reg;
  logic [2:0]      sync2_reg;
  logic [2:0]      db_reg;
  logic [2:0]      pend_reg;
  logic [2:0]      rise;
  logic [DB_W-1:0] cnt_reg [3];

  assign raw = {btnD, btnC, btnU};

  // The counter measures how long the synced level has disagreed with the accepted level;
  // a press is the cycle in which a high level is finally accepted.
  always_comb begin
    rise = '0;
    for (int i = 0; i < 3; i++) begin
      rise[i] = sync2_reg[i] & ~db_reg[i] & (cnt_reg[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      db_reg    <= '0;
      pend_reg  <= '0;
      for (int i = 0; i < 3; i++) cnt_reg[i] <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      // A press landing on the frame cycle survives into the next frame.
      pend_reg  <= frame ? rise : (pend_reg | rise);
      for (int i = 0; i < 3; i++) begin
        if (sync2_reg[i] == db_reg[i]) begin
          cnt_reg[i] <= '0;
        end else if (cnt_reg[i] == DB_LAST) begin
          db_reg[i]  <= sync2_reg[i];
          cnt_reg[i] <= '0;
        end else begin
          cnt_reg[i] <= cnt_reg[i] + DB_W'(1);
        end
      end
    end
  end

  mtype_t type_reg;
  mtype_t type_adv;
  mtype_t type_next;
  frz_t   frz_reg;
  logic   on_next;
  logic   frame_run;

  assign frame_run = frame && (frz_reg == RUN);

  always_comb begin
    type_adv  = T_NONE;
    type_next = type_reg;
    on_next   = membrane_on;
    case (type_reg)
      T_NONE:    type_adv = T_MAGENTA;
      T_MAGENTA: type_adv = T_RED;
      T_RED:     type_adv = T_BLUE;
      default:   type_adv = T_NONE;
    endcase
    if (frame_run && pend_reg[BU]) type_next = type_adv;
    if (type_next == T_NONE) on_next = 1'b0;
    else if (frame_run && pend_reg[BC] && (type_reg != T_NONE)) on_next = ~membrane_on;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      type_reg         <= T_NONE;
      frz_reg          <= RUN;
      no_membrane      <= 1'b1;
      magenta_membrane <= 1'b0;
      red_membrane     <= 1'b0;
      blue_membrane    <= 1'b0;
      membrane_on      <= 1'b0;
      freeze           <= 1'b0;
      freeze_left      <= '0;
    end else begin
      type_reg         <= type_next;
      no_membrane      <= (type_next == T_NONE);
      magenta_membrane <= (type_next == T_MAGENTA);
      red_membrane     <= (type_next == T_RED);
      blue_membrane    <= (type_next == T_BLUE);
      membrane_on      <= on_next;
      if (frame) begin
        if (frz_reg == RUN) begin
          if (pend_reg[BD]) begin
            frz_reg     <= FROZEN;
            freeze      <= 1'b1;
            freeze_left <= 8'(FREEZE_FRAMES);
          end
        end else if (pend_reg[BD] || (freeze_left == 8'd1)) begin
          frz_reg     <= RUN;
          freeze      <= 1'b0;
          freeze_left <= '0;
        end else begin
          freeze_left <= freeze_left - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_membrane_ctrl.sv
// Bench for membrane_ctrl: table of per-frame button waveforms with expected outputs,
// hand-written edge sequences, then random waveforms checked against a frame-level model.
module tb_membrane_ctrl;

  localparam int DB = 4;
  localparam int FF = 3;

  localparam logic [3:0] T_NO  = 4'b1000;
  localparam logic [3:0] T_MAG = 4'b0100;
  localparam logic [3:0] T_RED = 4'b0010;
  localparam logic [3:0] T_BLU = 4'b0001;
  localparam logic [13:0] RESET_VEC = {4'b1000, 1'b0, 1'b0, 8'd0};

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame;
  logic       btnU, btnC, btnD;
  logic       no_membrane, magenta_membrane, red_membrane, blue_membrane;
  logic       membrane_on, freeze;
  logic [7:0] freeze_left;
  logic [13:0] dut_vec;

  membrane_ctrl #(.DB_CYCLES(DB), .DB_W(3), .FREEZE_FRAMES(FF)) dut (
    .clk(clk), .reset_n(reset_n), .frame(frame),
    .btnU(btnU), .btnC(btnC), .btnD(btnD),
    .no_membrane(no_membrane), .magenta_membrane(magenta_membrane),
    .red_membrane(red_membrane), .blue_membrane(blue_membrane),
    .membrane_on(membrane_on), .freeze(freeze), .freeze_left(freeze_left)
  );

  always #5 clk = ~clk;

  assign dut_vec = {no_membrane, magenta_membrane, red_membrane, blue_membrane,
                    membrane_on, freeze, freeze_left};

  int total = 0;
  int bad   = 0;
  int frame_no = 0;

  // Frame-level reference: type 0..3 = none/magenta/red/blue.
  int m_type;
  bit m_on, m_frz;
  int m_left;
  bit m_pu, m_pc, m_pd;

  typedef struct {
    string       name;
    bit [49:0]   wu;
    bit [49:0]   wc;
    bit [49:0]   wd;
    logic [13:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic bit [49:0] run_at(int s, int len);
    bit [49:0] w = '0;
    for (int i = s; i < s + len; i++) w[i] = 1'b1;
    return w;
  endfunction

  // A waveform registers a press if it holds high for DB_CYCLES consecutive cycles.
  function automatic bit has_press(bit [49:0] w);
    int run = 0;
    for (int i = 0; i < 50; i++) begin
      run = w[i] ? run + 1 : 0;
      if (run >= DB) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit [49:0] gen_wave(int kind);
    bit [49:0] w = '0;
    int pos, n, len, s, l, g;
    case (kind)
      1: begin
        pos = 2;
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) begin
          len = $urandom_range(1, DB - 1);
          w |= run_at(pos, len);
          pos += len + $urandom_range(1, 4);
        end
      end
      2: w = run_at($urandom_range(2, 25), $urandom_range(DB, 12));
      3: begin
        s = $urandom_range(2, 8);
        l = $urandom_range(DB, 8);
        g = $urandom_range(DB, 8);
        w = run_at(s, l) | run_at(s + l + g, $urandom_range(DB, 10));
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [13:0] ev(logic [3:0] t, bit on, bit f, int left);
    return {t, on, f, 8'(left)};
  endfunction

  function automatic logic [13:0] model_vec();
    logic [3:0] t = 4'b1000;
    return {t >> m_type, m_on, m_frz, 8'(m_left)};
  endfunction

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (frame %0d)", name, act, exp, frame_no);
    end
  endtask

  task automatic model_reset();
    m_type = 0; m_on = 0; m_frz = 0; m_left = 0;
    m_pu = 0; m_pc = 0; m_pd = 0;
  endtask

  task automatic model_frame();
    int nt;
    if (!m_frz) begin
      if (m_pd) begin m_frz = 1; m_left = FF; end
      nt = m_pu ? (m_type + 1) % 4 : m_type;
      if (nt == 0) m_on = 0;
      else if (m_pc && m_type != 0) m_on = !m_on;
      m_type = nt;
    end else if (m_pd || m_left == 1) begin
      m_frz = 0; m_left = 0;
    end else begin
      m_left = m_left - 1;
    end
    m_pu = 0; m_pc = 0; m_pd = 0;
  endtask

  // 49 cycles of button waveform, frame asserted on the last one.
  task automatic interval(input bit [49:0] wu, input bit [49:0] wc, input bit [49:0] wd);
    for (int i = 0; i < 49; i++) begin
      @(posedge clk); #1;
      total++;
      if (!$onehot({no_membrane, magenta_membrane, red_membrane, blue_membrane})) begin
        bad++;
        $display("FAIL onehot: got %b required one-hot", {no_membrane, magenta_membrane,
                 red_membrane, blue_membrane});
      end
      if (i == 44) chk("hold", dut_vec, model_vec());
      btnU = wu[i]; btnC = wc[i]; btnD = wd[i];
      frame = (i == 48);
    end
  endtask

  task automatic post_frame();
    @(posedge clk); #1;
    frame = 0; btnU = 0; btnC = 0; btnD = 0;
    model_frame();
    frame_no++;
    $display("frame %0d: type=%b on=%b freeze=%b left=%0d", frame_no,
             {no_membrane, magenta_membrane, red_membrane, blue_membrane},
             membrane_on, freeze, freeze_left);
  endtask

  task automatic step(input bit [49:0] wu, input bit [49:0] wc, input bit [49:0] wd);
    interval(wu, wc, wd);
    m_pu |= has_press(wu);
    m_pc |= has_press(wc);
    m_pd |= has_press(wd);
    post_frame();
  endtask

  initial begin
    bit [49:0] z, p, gl, dbl, cw;
    z   = '0;
    p   = run_at(5, 8);
    gl  = run_at(2, 2) | run_at(5, 2) | run_at(8, 2);
    dbl = run_at(3, 6) | run_at(15, 6);

    tbl.push_back('{"glitch_only", gl, z, z, ev(T_NO, 0, 0, 0)});
    tbl.push_back('{"bounce_hold", gl | run_at(11, 20), z, z, ev(T_MAG, 0, 0, 0)});
    tbl.push_back('{"adv_red", p, z, z, ev(T_RED, 0, 0, 0)});
    tbl.push_back('{"adv_blue", p, z, z, ev(T_BLU, 0, 0, 0)});
    tbl.push_back('{"wrap_none", p, z, z, ev(T_NO, 0, 0, 0)});
    tbl.push_back('{"c_in_none", z, p, z, ev(T_NO, 0, 0, 0)});
    tbl.push_back('{"u_to_mag", p, z, z, ev(T_MAG, 0, 0, 0)});
    tbl.push_back('{"c_toggle_on", z, p, z, ev(T_MAG, 1, 0, 0)});
    tbl.push_back('{"u_red_on", p, z, z, ev(T_RED, 1, 0, 0)});
    tbl.push_back('{"u_blue_on", p, z, z, ev(T_BLU, 1, 0, 0)});
    tbl.push_back('{"u_none_off", p, z, z, ev(T_NO, 0, 0, 0)});
    tbl.push_back('{"u_mag", p, z, z, ev(T_MAG, 0, 0, 0)});
    tbl.push_back('{"d_freeze", z, z, p, ev(T_MAG, 0, 1, 3)});
    tbl.push_back('{"frozen_u_drop", p, z, z, ev(T_MAG, 0, 1, 2)});
    tbl.push_back('{"frozen_c_drop", z, p, z, ev(T_MAG, 0, 1, 1)});
    tbl.push_back('{"thaw", z, z, z, ev(T_MAG, 0, 0, 0)});
    tbl.push_back('{"d_again", z, z, p, ev(T_MAG, 0, 1, 3)});
    tbl.push_back('{"d_cancel", z, z, p, ev(T_MAG, 0, 0, 0)});
    tbl.push_back('{"u_c_d_same", p, p, p, ev(T_RED, 1, 1, 3)});
    tbl.push_back('{"tick2", z, z, z, ev(T_RED, 1, 1, 2)});
    tbl.push_back('{"tick1", z, z, z, ev(T_RED, 1, 1, 1)});
    tbl.push_back('{"tick0", z, z, z, ev(T_RED, 1, 0, 0)});
    tbl.push_back('{"u_double", dbl, z, z, ev(T_BLU, 1, 0, 0)});

    // Reset held while buttons toggle.
    reset_n = 0; frame = 0; btnU = 0; btnC = 0; btnD = 0;
    model_reset();
    repeat (10) begin
      @(posedge clk); #1;
      {btnU, btnC, btnD} = 3'($urandom);
    end
    chk("reset_hold", dut_vec, RESET_VEC);
    btnU = 0; btnC = 0; btnD = 0;
    repeat (6) @(posedge clk);
    #1 reset_n = 1;

    foreach (tbl[k]) begin
      step(tbl[k].wu, tbl[k].wc, tbl[k].wd);
      chk(tbl[k].name, dut_vec, tbl[k].exp);
    end

    // Press accepted exactly on the frame cycle: held over to the following frame.
    cw = run_at(43, 7);
    interval(cw, z, z);
    post_frame();
    chk("coincident_not_now", dut_vec, ev(T_BLU, 1, 0, 0));
    m_pu = 1;
    step(z, z, z);
    chk("coincident_next", dut_vec, ev(T_NO, 0, 0, 0));

    for (int n = 0; n < 60; n++) begin
      bit [49:0] ru, rc, rd;
      ru = gen_wave($urandom_range(0, 3));
      rc = gen_wave($urandom_range(0, 3));
      rd = ($urandom_range(0, 3) == 0) ? gen_wave(2 + $urandom_range(0, 1)) : gen_wave($urandom_range(0, 1));
      step(ru, rc, rd);
      chk("random", dut_vec, model_vec());
    end

    // Asynchronous reset mid-freeze with a debounced press still pending.
    for (int n = 0; n < 4; n++) if (m_frz) step(z, z, z);
    step(z, z, p);
    step(z, z, z);
    chk("pre_reset_left", {5'b0, freeze, freeze_left}, {5'b0, 1'b1, 8'd2});
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      btnU = (i < 10);
    end
    #2 reset_n = 0;
    #1 chk("async_reset", dut_vec, RESET_VEC);
    @(posedge clk); #1;
    reset_n = 1;
    model_reset();
    step(z, z, z);
    chk("press_lost", dut_vec, RESET_VEC);
    chk("post_reset_model", dut_vec, model_vec());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
